// File: rtl/keypad_digit_buffer.sv
// Multi-digit keypad entry buffer: shift-in digits, backspace, clear and commit,
// with a commit snapshot register and one-cycle err / guardado_valid pulses.
module keypad_digit_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGIT  = 9,
  parameter int OVF_ROLL   = 0,
  localparam int CW        = $clog2(NUM_DIGITS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIGIT_W-1:0]                 entrada,
  input  logic                               push,
  input  logic                               borrar,
  input  logic                               rst_dat,
  input  logic                               guardar,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0] numero,
  output logic [CW-1:0]                      count,
  output logic                               full,
  output logic                               err,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0] guardado_num,
  output logic                               guardado_valid
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DIGIT_W-1:0] L_MAX = DIGIT_W'(MAX_DIGIT);
  localparam logic [CW-1:0]      L_N   = CW'(NUM_DIGITS);
  localparam logic [CW-1:0]      L_ONE = CW'(1);

  logic [1:0]                        r_state;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_num;
  logic [CW-1:0]                     r_count;
  logic                              r_err;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_gnum;
  logic                              r_gvalid;

  logic [1:0]                        w_state;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_num;
  logic [CW-1:0]                     w_count;
  logic                              w_err;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_gnum;
  logic                              w_gvalid;
  logic                              w_dig_ok;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_shift_in;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_shift_out;

  assign w_dig_ok    = (entrada <= L_MAX);
  assign w_shift_in  = {r_num[NUM_DIGITS-2:0], entrada};
  assign w_shift_out = {{DIGIT_W{1'b0}}, r_num[NUM_DIGITS-1:1]};

  // One command per cycle, highest priority first; masked strobes are silently dropped.
  always_comb begin
    w_state  = r_state;
    w_num    = r_num;
    w_count  = r_count;
    w_err    = 1'b0;
    w_gnum   = r_gnum;
    w_gvalid = 1'b0;
    if (rst_dat) begin
      w_num   = '0;
      w_count = '0;
      w_state = S_EMPTY;
    end else if (guardar) begin
      if (r_state == S_ENTRY || r_state == S_FULL) begin
        w_gnum   = r_num;
        w_gvalid = 1'b1;
        w_state  = S_DONE;
      end else begin
        w_err = 1'b1;
      end
    end else if (borrar) begin
      case (r_state)
        S_EMPTY: w_err = 1'b1;
        S_DONE: begin
          w_num   = '0;
          w_count = '0;
          w_state = S_EMPTY;
        end
        default: begin
          w_num   = w_shift_out;
          w_count = r_count - L_ONE;
          w_state = (r_count == L_ONE) ? S_EMPTY : S_ENTRY;
        end
      endcase
    end else if (push) begin
      if (!w_dig_ok) begin
        w_err = 1'b1;
      end else begin
        case (r_state)
          S_FULL: begin
            // Roll mode keeps the buffer full and discards the oldest digit.
            if (OVF_ROLL != 0) w_num = w_shift_in;
            else               w_err = 1'b1;
          end
          S_DONE: begin
            w_num    = '0;
            w_num[0] = entrada;
            w_count  = L_ONE;
            w_state  = S_ENTRY;
          end
          default: begin
            w_num   = w_shift_in;
            w_count = r_count + L_ONE;
            w_state = (r_count + L_ONE == L_N) ? S_FULL : S_ENTRY;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_num    <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_gnum   <= '0;
      r_gvalid <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_num    <= w_num;
      r_count  <= w_count;
      r_err    <= w_err;
      r_gnum   <= w_gnum;
      r_gvalid <= w_gvalid;
    end
  end

  assign numero         = r_num;
  assign count          = r_count;
  assign full           = (r_state == S_FULL);
  assign err            = r_err;
  assign guardado_num   = r_gnum;
  assign guardado_valid = r_gvalid;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Bench for keypad_digit_buffer: two instances (reject and roll overflow policy)
// driven in lockstep and compared against an arithmetic model of the entry.
module tb_keypad_digit_buffer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int MX = 9;
  localparam int CW = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [D-1:0] entrada = '0;
  logic         push = 1'b0, borrar = 1'b0, rst_dat = 1'b0, guardar = 1'b0;

  logic [N-1:0][D-1:0] num0, num1, gnum0, gnum1;
  logic [CW-1:0]       cnt0, cnt1;
  logic                full0, full1, err0, err1, gv0, gv1;

  int total = 0;
  int bad   = 0;

  // Model: the entry is a base-2^D number; newest digit is the least significant.
  longint mv[2];
  int     mc[2];
  bit     mdone[2];
  longint mg[2];
  bit     merr[2];
  bit     mgv[2];

  always #5 clk = ~clk;

  keypad_digit_buffer #(.NUM_DIGITS(N), .DIGIT_W(D), .MAX_DIGIT(MX), .OVF_ROLL(0)) u_dut0 (
    .clk(clk), .rst(rst), .entrada(entrada), .push(push), .borrar(borrar),
    .rst_dat(rst_dat), .guardar(guardar), .numero(num0), .count(cnt0), .full(full0),
    .err(err0), .guardado_num(gnum0), .guardado_valid(gv0));

  keypad_digit_buffer #(.NUM_DIGITS(N), .DIGIT_W(D), .MAX_DIGIT(MX), .OVF_ROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .entrada(entrada), .push(push), .borrar(borrar),
    .rst_dat(rst_dat), .guardar(guardar), .numero(num1), .count(cnt1), .full(full1),
    .err(err1), .guardado_num(gnum1), .guardado_valid(gv1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rs, input bit rd, input bit gu, input bit bo,
                       input bit pu, input int e);
    longint base;
    longint modv;
    base = longint'(1) << D;
    modv = longint'(1) << (N * D);
    for (int m = 0; m < 2; m++) begin
      merr[m] = 1'b0;
      mgv[m]  = 1'b0;
      if (rs) begin
        mv[m] = 0; mc[m] = 0; mdone[m] = 1'b0; mg[m] = 0;
      end else if (rd) begin
        mv[m] = 0; mc[m] = 0; mdone[m] = 1'b0;
      end else if (gu) begin
        if (mc[m] > 0 && !mdone[m]) begin
          mg[m] = mv[m]; mgv[m] = 1'b1; mdone[m] = 1'b1;
        end else merr[m] = 1'b1;
      end else if (bo) begin
        if (mdone[m]) begin
          mv[m] = 0; mc[m] = 0; mdone[m] = 1'b0;
        end else if (mc[m] == 0) merr[m] = 1'b1;
        else begin
          mv[m] = mv[m] / base; mc[m]--;
        end
      end else if (pu) begin
        if (e > MX) merr[m] = 1'b1;
        else if (mdone[m]) begin
          mv[m] = e; mc[m] = 1; mdone[m] = 1'b0;
        end else if (mc[m] == N) begin
          if (m == 1) mv[m] = (mv[m] * base + e) % modv;
          else merr[m] = 1'b1;
        end else begin
          mv[m] = mv[m] * base + e; mc[m]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".num0"},  64'(num0),  64'(mv[0]));
    chk({tag, ".cnt0"},  64'(cnt0),  64'(mc[0]));
    chk({tag, ".full0"}, 64'(full0), 64'(mc[0] == N && !mdone[0]));
    chk({tag, ".err0"},  64'(err0),  64'(merr[0]));
    chk({tag, ".gnum0"}, 64'(gnum0), 64'(mg[0]));
    chk({tag, ".gv0"},   64'(gv0),   64'(mgv[0]));
    chk({tag, ".num1"},  64'(num1),  64'(mv[1]));
    chk({tag, ".cnt1"},  64'(cnt1),  64'(mc[1]));
    chk({tag, ".full1"}, 64'(full1), 64'(mc[1] == N && !mdone[1]));
    chk({tag, ".err1"},  64'(err1),  64'(merr[1]));
    chk({tag, ".gnum1"}, 64'(gnum1), 64'(mg[1]));
    chk({tag, ".gv1"},   64'(gv1),   64'(mgv[1]));
  endtask

  task automatic step(input string tag, input bit rs, input bit rd, input bit gu,
                      input bit bo, input bit pu, input int e);
    rst = rs; rst_dat = rd; guardar = gu; borrar = bo; push = pu;
    entrada = D'(e);
    @(posedge clk);
    model(rs, rd, gu, bo, pu, e);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; mc[m] = 0; mdone[m] = 0; mg[m] = 0; merr[m] = 0; mgv[m] = 0;
    end

    // Reset state
    step("reset", 1, 0, 0, 0, 0, 0);
    chk("reset_num", 64'(num0), 64'h0);
    step("idle", 0, 0, 0, 0, 0, 0);

    // Entry 1,2,3 then fill and overflow
    step("p1", 0, 0, 0, 0, 1, 1);
    step("p2", 0, 0, 0, 0, 1, 2);
    step("p3", 0, 0, 0, 0, 1, 3);
    chk("tp1_num", 64'(num0), 64'h0123);
    chk("tp1_cnt", 64'(cnt0), 64'd3);
    step("p4", 0, 0, 0, 0, 1, 4);
    chk("tp2_full", 64'(full0), 64'd1);
    step("p5", 0, 0, 0, 0, 1, 5);
    chk("tp2_noroll", 64'(num0), 64'h1234);
    chk("tp2_noroll_err", 64'(err0), 64'd1);
    chk("tp2_roll", 64'(num1), 64'h2345);
    chk("tp2_roll_err", 64'(err1), 64'd0);
    step("idle2", 0, 0, 0, 0, 0, 0);
    chk("tp2_errpulse", 64'(err0), 64'd0);

    // Backspace
    step("clr3", 0, 1, 0, 0, 0, 0);
    step("b_p1", 0, 0, 0, 0, 1, 1);
    step("b_p2", 0, 0, 0, 0, 1, 2);
    step("b_p3", 0, 0, 0, 0, 1, 3);
    step("bs1", 0, 0, 0, 1, 0, 0);
    chk("tp3_num", 64'(num0), 64'h0012);
    step("bs2", 0, 0, 0, 1, 0, 0);
    step("bs3", 0, 0, 0, 1, 0, 0);
    chk("tp3_empty", 64'(cnt0), 64'd0);
    step("bs4", 0, 0, 0, 1, 0, 0);
    chk("tp3_err", 64'(err0), 64'd1);

    // Invalid code
    step("inv", 0, 0, 0, 0, 1, 10);
    chk("tp4_err", 64'(err1), 64'd1);

    // Commit then fresh entry
    step("c_p7", 0, 0, 0, 0, 1, 7);
    step("c_p8", 0, 0, 0, 0, 1, 8);
    step("commit", 0, 0, 1, 0, 0, 0);
    chk("tp5_gnum", 64'(gnum0), 64'h0078);
    chk("tp5_gv", 64'(gv0), 64'd1);
    step("c_p5", 0, 0, 0, 0, 1, 5);
    chk("tp5_fresh", 64'(num0), 64'h0005);
    chk("tp5_hold", 64'(gnum0), 64'h0078);
    step("c_clr", 0, 1, 0, 0, 0, 0);
    step("c_gempty", 0, 0, 1, 0, 0, 0);
    chk("tp5_err", 64'(err0), 64'd1);

    // Same-cycle priority, then reset over push
    step("q_p9", 0, 0, 0, 0, 1, 9);
    step("q_pg", 0, 0, 1, 0, 1, 3);
    chk("tp6_gnum", 64'(gnum0), 64'h0009);
    step("q_rst", 1, 0, 0, 0, 1, 4);
    chk("tp6_rst_g", 64'(gnum1), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rs, rd, gu, bo, pu;
      rs = ($urandom_range(0, 99) < 2);
      rd = ($urandom_range(0, 19) == 0);
      gu = ($urandom_range(0, 9) == 0);
      bo = ($urandom_range(0, 5) == 0);
      pu = ($urandom_range(0, 1) == 1);
      step("rand", rs, rd, gu, bo, pu, int'($urandom_range(0, 11)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
